// File: rtl/uart_protocal_rx_stm.sv
// UART receive protocol engine.
// Oversamples the serial line at 16 ticks per bit, frames start/data/parity/stop
// bits and hands each good byte to the Rx FIFO with a one-cycle write strobe.
// Parity and framing failures, and bytes dropped on a full FIFO, are reported
// as one-cycle status pulses in place of the write.
module uart_protocal_rx_stm (
    input  logic       glb_clk,
    input  logic       glb_rstn,
    input  logic       CFG_PROT_ctrl_Rxen,
    input  logic [7:0] CFG_PROT_data_baudcmp,
    input  logic       parity_cfg,
    input  logic       stop_cfg,
    input  logic       USR_PROT_data_rxd,
    input  logic       Rx_FIFO_full,
    output logic       PROT_CFG_ctrl_rx_w_en,
    output logic [7:0] PROT_CFG_data_rx_data,
    output logic       USR_PROT_ctrl_rts,
    output logic       PROT_CFG_stat_parity_err,
    output logic       PROT_CFG_stat_frame_err,
    output logic       PROT_CFG_stat_overrun,
    output logic       PROT_CFG_ctrl_rx_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    logic       rxd_meta;
    logic       rxd_s;
    logic       rxd_prev;

    logic [2:0] state;
    logic [2:0] next_state;

    logic [7:0] tick_cnt;
    logic [3:0] smp_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

    logic [7:0] baud_lat;
    logic       parity_lat;
    logic       stop_lat;
    logic       perr_flag;
    logic       ferr_flag;

    logic       tick;
    logic       fall_edge;
    logic       sample_pt;
    logic       abort;
    logic       commit;
    logic       frame_bad;

    assign tick      = (tick_cnt == baud_lat);
    assign fall_edge = rxd_prev & ~rxd_s;
    assign sample_pt = tick && (smp_cnt == 4'd15);
    assign abort     = (state != ST_IDLE) && !CFG_PROT_ctrl_Rxen;
    // The stop bit being sampled right now counts toward the framing verdict.
    assign frame_bad = ferr_flag | ~rxd_s;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge glb_clk) begin
        if (!glb_rstn) begin
            // NOTE: idle-high reset values keep a reset release from looking like a start edge.
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value.
            rxd_meta <= USR_PROT_data_rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // Next-state decode; commit marks the final stop-bit sample of a frame.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        next_state = state;
        commit     = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CFG_PROT_ctrl_Rxen && fall_edge) next_state = ST_START;
                end
                ST_START: begin
                    if (tick && (smp_cnt == 4'd7)) next_state = rxd_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample_pt && (bit_idx == 3'd7)) next_state = parity_lat ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: begin
                    if (sample_pt) next_state = ST_STOP1;
                end
                ST_STOP1: begin
                    if (sample_pt) begin
                        if (stop_lat) begin
                            next_state = ST_STOP2;
                        end else begin
                            next_state = ST_IDLE;
                            commit     = 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (sample_pt) begin
                        next_state = ST_IDLE;
                        commit     = 1'b1;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Baud tick divider and 16x sample counter; both parked at zero outside a frame.
    always_ff @(posedge glb_clk) begin
        if (!glb_rstn) begin
            tick_cnt <= 8'd0;
            smp_cnt  <= 4'd0;
        end else if ((state == ST_IDLE) || (next_state == ST_IDLE)) begin
            tick_cnt <= 8'd0;
            smp_cnt  <= 4'd0;
        end else begin
            tick_cnt <= tick ? 8'd0 : tick_cnt + 8'd1;
            if (tick) begin
                // Start bit is re-centred: after its mid-point the count restarts for data.
                smp_cnt <= ((state == ST_START) && (smp_cnt == 4'd7)) ? 4'd0 : smp_cnt + 4'd1;
            end
        end
    end

    // Frame state, per-frame configuration snapshot, data shifter and error flags.
    always_ff @(posedge glb_clk) begin
        if (!glb_rstn) begin
            state      <= ST_IDLE;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            baud_lat   <= 8'd0;
            parity_lat <= 1'b0;
            stop_lat   <= 1'b0;
            perr_flag  <= 1'b0;
            ferr_flag  <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && (next_state == ST_START)) begin
                baud_lat   <= CFG_PROT_data_baudcmp;
                parity_lat <= parity_cfg;
                stop_lat   <= stop_cfg;
                bit_idx    <= 3'd0;
                perr_flag  <= 1'b0;
                ferr_flag  <= 1'b0;
            end
            if (!abort && sample_pt) begin
                case (state)
                    ST_DATA: begin
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end
                    ST_PARITY: begin
                        if (rxd_s != ^shift_reg) perr_flag <= 1'b1;
                    end
                    ST_STOP1, ST_STOP2: begin
                        if (!rxd_s) ferr_flag <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs: one pulse per committed frame, plus rts and busy.
    always_ff @(posedge glb_clk) begin
        if (!glb_rstn) begin
            PROT_CFG_ctrl_rx_w_en    <= 1'b0;
            PROT_CFG_data_rx_data    <= 8'h00;
            PROT_CFG_stat_parity_err <= 1'b0;
            PROT_CFG_stat_frame_err  <= 1'b0;
            PROT_CFG_stat_overrun    <= 1'b0;
            USR_PROT_ctrl_rts        <= 1'b0;
            PROT_CFG_ctrl_rx_busy    <= 1'b0;
        end else begin
            PROT_CFG_ctrl_rx_w_en    <= 1'b0;
            PROT_CFG_stat_parity_err <= 1'b0;
            PROT_CFG_stat_frame_err  <= 1'b0;
            PROT_CFG_stat_overrun    <= 1'b0;
            if (commit) begin
                if (frame_bad) begin
                    PROT_CFG_stat_frame_err <= 1'b1;
                end else if (perr_flag) begin
                    PROT_CFG_stat_parity_err <= 1'b1;
                end else if (Rx_FIFO_full) begin
                    PROT_CFG_stat_overrun <= 1'b1;
                end else begin
                    PROT_CFG_ctrl_rx_w_en <= 1'b1;
                    PROT_CFG_data_rx_data <= shift_reg;
                end
            end
            USR_PROT_ctrl_rts     <= CFG_PROT_ctrl_Rxen & ~Rx_FIFO_full;
            PROT_CFG_ctrl_rx_busy <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_protocal_rx_stm.sv
// Directed testbench for uart_protocal_rx_stm.
// Drives whole serial frames bit by bit and counts output pulses on the falling
// clock edge; each scenario task compares pulse counts and data to hand-derived values.
module tb_uart_protocal_rx_stm;

    logic       glb_clk  = 1'b0;
    logic       glb_rstn = 1'b0;
    logic       rxen     = 1'b0;
    logic [7:0] baud     = 8'd0;
    logic       par      = 1'b0;
    logic       stp      = 1'b0;
    logic       rxd      = 1'b1;
    logic       full     = 1'b0;

    logic       w_en;
    logic [7:0] rx_data;
    logic       rts;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         n_wr   = 0;
    int         n_perr = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    logic [7:0] wr_data = 8'h00;
    int         wr_cyc  = 0;

    int b_wr, b_perr, b_ferr, b_ovr;
    int t_start;

    uart_protocal_rx_stm dut (
        .glb_clk                  (glb_clk),
        .glb_rstn                 (glb_rstn),
        .CFG_PROT_ctrl_Rxen       (rxen),
        .CFG_PROT_data_baudcmp    (baud),
        .parity_cfg               (par),
        .stop_cfg                 (stp),
        .USR_PROT_data_rxd        (rxd),
        .Rx_FIFO_full             (full),
        .PROT_CFG_ctrl_rx_w_en    (w_en),
        .PROT_CFG_data_rx_data    (rx_data),
        .USR_PROT_ctrl_rts        (rts),
        .PROT_CFG_stat_parity_err (perr),
        .PROT_CFG_stat_frame_err  (ferr),
        .PROT_CFG_stat_overrun    (ovr),
        .PROT_CFG_ctrl_rx_busy    (busy)
    );

    always #5 glb_clk = ~glb_clk;

    always @(posedge glb_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge glb_clk) begin
        if (w_en) begin
            n_wr    = n_wr + 1;
            wr_data = rx_data;
            wr_cyc  = cyc;
        end
        if (perr) n_perr = n_perr + 1;
        if (ferr) n_ferr = n_ferr + 1;
        if (ovr)  n_ovr  = n_ovr + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge glb_clk);
        #1;
    endtask

    task automatic snap();
        b_wr   = n_wr;
        b_perr = n_perr;
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
    endtask

    task automatic expect_pulses(input string name, input int wr, input int pe, input int fe, input int ov);
        checks++;
        if ((n_wr - b_wr) !== wr || (n_perr - b_perr) !== pe ||
            (n_ferr - b_ferr) !== fe || (n_ovr - b_ovr) !== ov) begin
            failures++;
            $display("FAIL %s pulses wr/perr/ferr/ovr got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     name, n_wr - b_wr, n_perr - b_perr, n_ferr - b_ferr, n_ovr - b_ovr,
                     wr, pe, fe, ov);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %02h want %02h", name, got, want);
        end
    endtask

    // One full frame; scramble flips the config inputs after the start bit and restores them at the end.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic s1, input logic s2, input logic two, input logic scramble);
        int         bp;
        logic [7:0] sv_baud;
        logic       sv_par;
        logic       sv_stp;
        bp      = 16 * (int'(baud) + 1);
        sv_baud = baud;
        sv_par  = par;
        sv_stp  = stp;
        t_start = cyc;
        rxd = 1'b0;
        wait_clk(bp);
        if (scramble) begin
            baud = baud + 8'd4;
            par  = ~par;
            stp  = ~stp;
        end
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(bp);
        end
        if (pen) begin
            rxd = pbit;
            wait_clk(bp);
        end
        rxd = s1;
        wait_clk(bp);
        if (two) begin
            rxd = s2;
            wait_clk(bp);
        end
        rxd = 1'b1;
        wait_clk(2 * bp);
        if (scramble) begin
            baud = sv_baud;
            par  = sv_par;
            stp  = sv_stp;
        end
    endtask

    task automatic test_reset();
        rxen = 1'b1;
        wait_clk(3);
        expect_bit("reset_w_en", w_en, 1'b0);
        expect_byte("reset_rx_data", rx_data, 8'h00);
        expect_bit("reset_rts", rts, 1'b0);
        expect_bit("reset_busy", busy, 1'b0);
        expect_bit("reset_errs", perr | ferr | ovr, 1'b0);
        glb_rstn = 1'b1;
        wait_clk(2);
        expect_bit("post_reset_rts", rts, 1'b1);
        expect_bit("post_reset_busy", busy, 1'b0);
    endtask

    task automatic test_basic();
        int lat;
        baud = 8'd0; par = 1'b0; stp = 1'b0;
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("basic_a5", 1, 0, 0, 0);
        expect_byte("basic_a5_data", wr_data, 8'hA5);
        // Start edge is seen two clocks after the line falls (synchronizer).
        lat = wr_cyc - (t_start + 2);
        checks++;
        if (lat < 151 || lat > 153) begin
            failures++;
            $display("FAIL basic_latency got %0d want 151..153", lat);
        end
        expect_bit("basic_busy_idle", busy, 1'b0);
    endtask

    task automatic test_parity();
        baud = 8'd1; par = 1'b1; stp = 1'b0;
        snap();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("parity_good", 1, 0, 0, 0);
        expect_byte("parity_good_data", wr_data, 8'h03);
        snap();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("parity_bad", 0, 1, 0, 0);
        expect_byte("parity_bad_hold", rx_data, 8'h03);
    endtask

    task automatic test_frame_err();
        baud = 8'd0; par = 1'b0; stp = 1'b1;
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_pulses("frame_stop2_low", 0, 0, 1, 0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_pulses("frame_recover", 1, 0, 0, 0);
        expect_byte("frame_recover_data", wr_data, 8'h5A);
        // Line stuck low through and past the stop bit: one error, no re-trigger.
        stp = 1'b0;
        snap();
        rxd = 1'b0;
        wait_clk(13 * 16);
        rxd = 1'b1;
        wait_clk(32);
        expect_pulses("frame_held_low", 0, 0, 1, 0);
        expect_bit("frame_held_low_busy", busy, 1'b0);
    endtask

    task automatic test_overrun();
        baud = 8'd0; par = 1'b0; stp = 1'b0;
        full = 1'b1;
        wait_clk(2);
        expect_bit("overrun_rts", rts, 1'b0);
        snap();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("overrun_11", 0, 0, 0, 1);
        expect_byte("overrun_hold", rx_data, 8'h5A);
        full = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_glitch();
        baud = 8'd0;
        snap();
        rxd = 1'b0;
        wait_clk(4);
        rxd = 1'b1;
        wait_clk(1);
        expect_bit("glitch_busy_set", busy, 1'b1);
        wait_clk(20);
        expect_bit("glitch_busy_clear", busy, 1'b0);
        expect_pulses("glitch_none", 0, 0, 0, 0);
    endtask

    task automatic test_cfg_latch();
        baud = 8'd1; par = 1'b0; stp = 1'b0;
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_pulses("cfg_latch", 1, 0, 0, 0);
        expect_byte("cfg_latch_data", wr_data, 8'h3C);
    endtask

    task automatic test_abort();
        baud = 8'd0; par = 1'b0; stp = 1'b0;
        snap();
        rxd = 1'b0;
        wait_clk(16 * 4 + 8);
        rxen = 1'b0;
        wait_clk(2);
        expect_bit("abort_busy", busy, 1'b0);
        expect_bit("abort_rts", rts, 1'b0);
        rxd = 1'b1;
        wait_clk(16);
        rxen = 1'b1;
        wait_clk(32);
        expect_pulses("abort_none", 0, 0, 0, 0);
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("abort_then_ff", 1, 0, 0, 0);
        expect_byte("abort_then_ff_data", wr_data, 8'hFF);
    endtask

    task automatic test_reset_mid_frame();
        baud = 8'd0; par = 1'b0; stp = 1'b0;
        snap();
        rxd = 1'b0;
        wait_clk(16 * 3);
        glb_rstn = 1'b0;
        rxd = 1'b1;
        wait_clk(3);
        glb_rstn = 1'b1;
        wait_clk(32);
        expect_pulses("rst_mid_none", 0, 0, 0, 0);
        expect_byte("rst_mid_data", rx_data, 8'h00);
        expect_bit("rst_mid_busy", busy, 1'b0);
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pulses("rst_then_ff", 1, 0, 0, 0);
        expect_byte("rst_then_ff_data", wr_data, 8'hFF);
    endtask

    initial begin
        wait_clk(1);
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_cfg_latch();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
